control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/control_unit.sv | 179 +++++++++++++++++
 tb/tb_control_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple 8-bit CPU: FSM state encodings, opcode
// values and bus select encodings. The datapath imports the same package so
// that both sides agree on what a select code means.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  // bus_1 sources
  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_PC = 3'd4;

  // bus_2 sources (code 3 is never driven)
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  // Register field 0..3 -> bus_1 select R0..R3
  function automatic logic [2:0] reg_sel(input logic [1:0] idx);
    return {1'b0, idx};
  endfunction

  // Register field 0..3 -> one-hot load enable, bit N = load_rN
  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: sequencing FSM for the simple 8-bit CPU.
// Ports:
//   clk, rst (async, active-low)
//   instruction  : IR contents, [7:4] opcode, [3:2] src, [1:0] dest
//   zero_flag    : registered ALU zero flag
//   load_r0..r3, load_pc, load_y, load_z, load_ir, load_addr : load enables
//   inc_pc       : program counter increment
//   sel_bus_1_mux: bus_1 source (R0..R3, PC)
//   sel_bus_2_mux: bus_2 source (ALU, bus_1, memory)
//   write        : memory write strobe
//   halted       : high while in HALT
// All outputs are decoded combinationally from the state register,
// the instruction and zero_flag.
module control_unit
  import cpu_pkg::*;
#(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int sel1_size  = 3,
  parameter int sel2_size  = 2,
  parameter int state_size = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero_flag,
  output logic                 load_r0,
  output logic                 load_r1,
  output logic                 load_r2,
  output logic                 load_r3,
  output logic                 load_pc,
  output logic                 load_y,
  output logic                 load_z,
  output logic                 load_ir,
  output logic                 load_addr,
  output logic                 inc_pc,
  output logic [sel1_size-1:0] sel_bus_1_mux,
  output logic [sel2_size-1:0] sel_bus_2_mux,
  output logic                 write,
  output logic                 halted
);

  logic [state_size-1:0] state_q, state_d;
  logic [op_size-1:0]    opcode;
  logic [1:0]            src, dest;
  logic [3:0]            load_r;

  assign opcode = instruction[word_size-1 -: op_size];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  assign load_r0 = load_r[0];
  assign load_r1 = load_r[1];
  assign load_r2 = load_r[2];
  assign load_r3 = load_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_r        = 4'b0000;
    load_pc       = 1'b0;
    load_y        = 1'b0;
    load_z        = 1'b0;
    load_ir       = 1'b0;
    load_addr     = 1'b0;
    inc_pc        = 1'b0;
    sel_bus_1_mux = SEL1_R0;
    sel_bus_2_mux = SEL2_ALU;
    write         = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FET1;

      S_FET1: begin
        sel_bus_1_mux = SEL1_PC;
        sel_bus_2_mux = SEL2_BUS1;
        load_addr     = 1'b1;
        inc_pc        = 1'b1;
        state_d       = S_FET2;
      end

      S_FET2: begin
        sel_bus_2_mux = SEL2_MEM;
        load_ir       = 1'b1;
        state_d       = S_DEC;
      end

      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FET1;

          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus_1_mux = reg_sel(src);
            sel_bus_2_mux = SEL2_BUS1;
            load_y        = 1'b1;
            state_d       = S_EX1;
          end

          OP_NOT: begin
            sel_bus_1_mux = reg_sel(src);
            sel_bus_2_mux = SEL2_ALU;
            load_z        = 1'b1;
            load_r        = reg_onehot(dest);
            state_d       = S_FET1;
          end

          OP_RD, OP_WR, OP_BR, OP_BRZ: begin
            // A not-taken BRZ only steps the PC past its operand byte.
            if (opcode == OP_BRZ && !zero_flag) begin
              inc_pc  = 1'b1;
              state_d = S_FET1;
            end else begin
              sel_bus_1_mux = SEL1_PC;
              sel_bus_2_mux = SEL2_BUS1;
              load_addr     = 1'b1;
              case (opcode)
                OP_RD:   state_d = S_RD1;
                OP_WR:   state_d = S_WR1;
                default: state_d = S_BR1;
              endcase
            end
          end

          default: state_d = S_HALT;
        endcase
      end

      S_EX1: begin
        sel_bus_1_mux = reg_sel(dest);
        sel_bus_2_mux = SEL2_ALU;
        load_z        = 1'b1;
        load_r        = reg_onehot(dest);
        state_d       = S_FET1;
      end

      S_RD1, S_WR1: begin
        // Operand byte holds the data address; load it and skip past it.
        sel_bus_2_mux = SEL2_MEM;
        load_addr     = 1'b1;
        inc_pc        = 1'b1;
        state_d       = (state_q == S_RD1) ? S_RD2 : S_WR2;
      end

      S_RD2: begin
        sel_bus_2_mux = SEL2_MEM;
        load_r        = reg_onehot(dest);
        state_d       = S_FET1;
      end

      S_WR2: begin
        sel_bus_1_mux = reg_sel(src);
        write         = 1'b1;
        state_d       = S_FET1;
      end

      S_BR1: begin
        sel_bus_2_mux = SEL2_MEM;
        load_addr     = 1'b1;
        state_d       = S_BR2;
      end

      S_BR2: begin
        sel_bus_2_mux = SEL2_MEM;
        load_pc       = 1'b1;
        state_d       = S_FET1;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: table of per-cycle vectors walked from reset
// through every instruction class, then hand sequences for HALT hold,
// reset out of HALT and reset in the middle of a write.
module tb_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       zero_flag = 1'b0;
  logic load_r0, load_r1, load_r2, load_r3, load_pc, load_y, load_z;
  logic load_ir, load_addr, inc_pc, write, halted;
  logic [2:0] sel_bus_1_mux;
  logic [1:0] sel_bus_2_mux;

  control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero_flag(zero_flag),
    .load_r0(load_r0), .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
    .load_pc(load_pc), .load_y(load_y), .load_z(load_z), .load_ir(load_ir),
    .load_addr(load_addr), .inc_pc(inc_pc), .sel_bus_1_mux(sel_bus_1_mux),
    .sel_bus_2_mux(sel_bus_2_mux), .write(write), .halted(halted)
  );

  always #5 clk = ~clk;

  // Packed view: {load_r3..r0, pc, y, z, ir, addr, inc, write, halted, sel1, sel2}
  localparam logic [7:0] F_PC = 8'h80, F_Y = 8'h40, F_Z = 8'h20, F_IR = 8'h10;
  localparam logic [7:0] F_ADDR = 8'h08, F_INC = 8'h04, F_WR = 8'h02, F_HLT = 8'h01;

  logic [16:0] got;
  assign got = {load_r3, load_r2, load_r1, load_r0, load_pc, load_y, load_z,
                load_ir, load_addr, inc_pc, write, halted,
                sel_bus_1_mux, sel_bus_2_mux};

  function automatic logic [16:0] mk(input logic [2:0] s1, input logic [1:0] s2,
                                     input logic [3:0] lr, input logic [7:0] f);
    return {lr, f, s1, s2};
  endfunction

  typedef struct {
    logic [7:0]  instr;
    logic        zf;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;
  int write_pulses = 0;
  logic count_writes = 1'b0;

  logic [16:0] e_f1, e_f2, e_idle, e_addr_pc, e_halt;

  always @(posedge write) if (count_writes) write_pulses++;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%05h expected=%05h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] i, input logic z, input logic [16:0] e);
    vec_t v;
    v.instr = i; v.zf = z; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input logic [7:0] i, input logic z);
    add(i, z, e_f1);
    add(i, z, e_f2);
  endtask

  // One cycle: drive at negedge, sample 1 ns later.
  task automatic step(input logic [7:0] i, input logic z);
    @(negedge clk);
    instruction = i;
    zero_flag   = z;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    e_idle    = '0;
    e_f1      = mk(3'd4, 2'd1, 4'b0000, F_ADDR | F_INC);
    e_f2      = mk(3'd0, 2'd2, 4'b0000, F_IR);
    e_addr_pc = mk(3'd4, 2'd1, 4'b0000, F_ADDR);
    e_halt    = mk(3'd0, 2'd0, 4'b0000, F_HLT);

    // IDLE after reset release
    add(8'h00, 1'b0, e_idle);
    // NOP: 3 cycles
    add_fetch(8'h00, 1'b0); add(8'h00, 1'b0, e_idle);
    // ADD R1,R2
    add_fetch(8'h16, 1'b0);
    add(8'h16, 1'b0, mk(3'd1, 2'd1, 4'b0000, F_Y));
    add(8'h16, 1'b0, mk(3'd2, 2'd0, 4'b0100, F_Z));
    // RD R3
    add_fetch(8'h53, 1'b0);
    add(8'h53, 1'b0, e_addr_pc);
    add(8'h53, 1'b0, mk(3'd0, 2'd2, 4'b0000, F_ADDR | F_INC));
    add(8'h53, 1'b0, mk(3'd0, 2'd2, 4'b1000, 8'h00));
    // WR src=R3
    add_fetch(8'h6E, 1'b0);
    add(8'h6E, 1'b0, e_addr_pc);
    add(8'h6E, 1'b0, mk(3'd0, 2'd2, 4'b0000, F_ADDR | F_INC));
    add(8'h6E, 1'b0, mk(3'd3, 2'd0, 4'b0000, F_WR));
    // BRZ not taken
    add_fetch(8'h80, 1'b0);
    add(8'h80, 1'b0, mk(3'd0, 2'd0, 4'b0000, F_INC));
    // BRZ taken
    add_fetch(8'h80, 1'b1);
    add(8'h80, 1'b1, e_addr_pc);
    add(8'h80, 1'b1, mk(3'd0, 2'd2, 4'b0000, F_ADDR));
    add(8'h80, 1'b1, mk(3'd0, 2'd2, 4'b0000, F_PC));
    // BR with zero_flag low is still taken
    add_fetch(8'h70, 1'b0);
    add(8'h70, 1'b0, e_addr_pc);
    add(8'h70, 1'b0, mk(3'd0, 2'd2, 4'b0000, F_ADDR));
    add(8'h70, 1'b0, mk(3'd0, 2'd2, 4'b0000, F_PC));
    // NOT src=R3 dest=R1
    add_fetch(8'h4D, 1'b0);
    add(8'h4D, 1'b0, mk(3'd3, 2'd0, 4'b0010, F_Z));
    // SUB src=R3 dest=R0
    add_fetch(8'h2C, 1'b0);
    add(8'h2C, 1'b0, mk(3'd3, 2'd1, 4'b0000, F_Y));
    add(8'h2C, 1'b0, mk(3'd0, 2'd0, 4'b0001, F_Z));
    // AND src=R0 dest=R1
    add_fetch(8'h31, 1'b1);
    add(8'h31, 1'b1, mk(3'd0, 2'd1, 4'b0000, F_Y));
    add(8'h31, 1'b1, mk(3'd1, 2'd0, 4'b0010, F_Z));
    // Illegal opcode -> HALT
    add_fetch(8'hF0, 1'b0);
    add(8'hF0, 1'b0, e_idle);

    // Outputs while held in reset
    #3;
    check("reset_outputs", got, e_idle);
    @(negedge clk);
    #1;
    check("reset_hold", got, e_idle);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) step(tbl[i].instr, tbl[i].zf);
      else begin
        instruction = tbl[i].instr; zero_flag = tbl[i].zf; #1;
      end
      check($sformatf("vec%0d_op%02h", i, tbl[i].instr), got, tbl[i].exp);
    end

    // HALT held for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(8'hF0, i[0]);
      check($sformatf("halt_hold%0d", i), got, e_halt);
    end

    // Async reset in the middle of HALT
    #1 rst = 1'b0;
    #1;
    check("halt_async_reset", got, e_idle);
    @(posedge clk); #1;
    check("halt_reset_held", got, e_idle);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_halt_idle", got, e_idle);
    step(8'h00, 1'b0);
    check("post_halt_fet1", got, e_f1);

    // Run a WR to WR1, then reset mid-cycle
    step(8'h00, 1'b0); // FET2
    step(8'h00, 1'b0); // DEC NOP
    step(8'h6E, 1'b0);
    check("wr_fet1", got, e_f1);
    step(8'h6E, 1'b0);
    step(8'h6E, 1'b0);
    check("wr_dec", got, e_addr_pc);
    step(8'h6E, 1'b0);
    check("wr1", got, mk(3'd0, 2'd2, 4'b0000, F_ADDR | F_INC));
    count_writes = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("wr1_async_reset", got, e_idle);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("after_wr_reset_idle", got, e_idle);
    step(8'h6E, 1'b0);
    check("after_wr_reset_fet1", got, e_f1);
    step(8'h6E, 1'b0);
    check("after_wr_reset_fet2", got, e_f2);
    count_writes = 1'b0;
    checks++;
    if (write_pulses != 0) begin
      failures++;
      $display("FAIL write_never_pulsed got=%0d expected=0", write_pulses);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
